// File: rtl/serial_echo_engine.sv
// Purpose : buffers received words in a FIFO, transforms each one and hands it to a UART
//           transmitter over a ready/copied handshake; drives active-low RX/TX activity LEDs.
// Latency : 2 cycles from the capture edge to tx_data_ready when the TX FSM is idle.
// Backpressure: the transmitter stalls via tx_data_copied/tx_busy. Words arriving at a full FIFO
//           (with no pop that cycle) are dropped and set the sticky overflow flag.
// Ports   : clk/rst (async, active-high); rx_byte_received/rx_data/rx_err from the receiver;
//           mode selects the transform; clr_status clears overflow/err_count;
//           tx_data/tx_data_ready/tx_data_copied/tx_busy to the transmitter;
//           rx_led/tx_led activity LEDs; fifo_count/overflow/err_count status.

// One-shot LED blinker: a trigger in AWAIT turns the LED on (low) for BLINK_CYCLES cycles,
// followed by a BLINK_CYCLES off-guard in which further triggers are ignored.
module led_blinker #(
    parameter int BLINK_CYCLES = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic led
);
    localparam int CNT_W = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {L_AWAIT, L_ON, L_OFF} led_state_t;

    led_state_t           state;
    led_state_t           state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 last;

    assign last = (cnt == CNT_W'(BLINK_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= L_AWAIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            L_AWAIT: begin
                if (trig) begin
                    state_nxt = L_ON;
                    cnt_nxt   = '0;
                end
            end
            L_ON: begin
                if (last) begin
                    state_nxt = L_OFF;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            L_OFF: begin
                if (last) begin
                    state_nxt = L_AWAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = L_AWAIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign led = (state != L_ON);
endmodule

module serial_echo_engine #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    FIFO_DEPTH   = 16,
    parameter int                    ADD_VALUE    = 1,
    parameter logic [DATA_WIDTH-1:0] XOR_KEY      = 8'h55,
    parameter int                    BLINK_CYCLES = 10000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_byte_received,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_err,
    input  logic [1:0]                    mode,
    input  logic                          clr_status,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_data_ready,
    input  logic                          tx_data_copied,
    input  logic                          tx_busy,
    output logic                          rx_led,
    output logic                          tx_led,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} tx_state_t;

    // ---------------- capture ----------------
    logic rx_q;
    logic capture;
    logic push;
    logic push_ok;
    logic drop;
    logic err_evt;
    logic pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_q <= 1'b0;
        else     rx_q <= rx_byte_received;
    end

    assign capture = rx_byte_received & ~rx_q;
    assign push    = capture & ~rx_err;
    assign err_evt = capture & rx_err;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok = push & ((fifo_count != CW'(FIFO_DEPTH)) | pop);
    assign drop    = push & ~push_ok;

    // ---------------- FIFO ----------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            // New events win over a clear arriving in the same cycle.
            if (drop)            overflow <= 1'b1;
            else if (clr_status) overflow <= 1'b0;

            if (err_evt) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (clr_status) begin
                err_count <= 8'd0;
            end
        end
    end

    // ---------------- transform ----------------
    function automatic logic [DATA_WIDTH-1:0] xform(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [1:0]            m);
        logic [DATA_WIDTH-1:0] r;
        r = x;
        case (m)
            2'd1: r = x + DATA_WIDTH'(ADD_VALUE);
            2'd2: r = x ^ XOR_KEY;
            2'd3: for (int i = 0; i < DATA_WIDTH; i++) r[i] = x[DATA_WIDTH-1-i];
            default: r = x;
        endcase
        return r;
    endfunction

    // ---------------- TX FSM ----------------
    tx_state_t state;
    tx_state_t state_nxt;
    logic      ready_nxt;
    logic      wait_done;
    logic      wait_nxt;
    logic      tx_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            tx_data_ready <= 1'b0;
            wait_done     <= 1'b0;
            tx_data       <= '0;
        end else begin
            state         <= state_nxt;
            tx_data_ready <= ready_nxt;
            wait_done     <= wait_nxt;
            // mode is sampled only when the word leaves the FIFO.
            if (pop) tx_data <= xform(mem[rd_ptr], mode);
        end
    end

    always_comb begin
        state_nxt = state;
        ready_nxt = tx_data_ready;
        wait_nxt  = wait_done;
        pop       = 1'b0;
        tx_evt    = 1'b0;
        case (state)
            S_IDLE: begin
                ready_nxt = 1'b0;
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    tx_evt    = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // Only a copy seen while the request is visible completes the handshake.
                if (tx_data_ready && tx_data_copied) begin
                    ready_nxt = 1'b0;
                    wait_nxt  = 1'b0;
                    state_nxt = S_WAIT;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                // wait_done marks the first WAIT cycle as spent, giving a 2-cycle minimum.
                wait_nxt = 1'b1;
                if (wait_done && !tx_busy) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                ready_nxt = 1'b0;
            end
        endcase
    end

    // ---------------- LEDs ----------------
    led_blinker #(.BLINK_CYCLES(BLINK_CYCLES)) u_rx_led (
        .clk  (clk),
        .rst  (rst),
        .trig (push_ok),
        .led  (rx_led)
    );

    led_blinker #(.BLINK_CYCLES(BLINK_CYCLES)) u_tx_led (
        .clk  (clk),
        .rst  (rst),
        .trig (tx_evt),
        .led  (tx_led)
    );
endmodule

// File: tb/tb_serial_echo_engine.sv
module tb_serial_echo_engine;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int BLINK = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_byte_received = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_err = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          clr_status = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_data_ready;
    logic          tx_data_copied = 1'b0;
    logic          tx_busy = 1'b0;
    logic          rx_led;
    logic          tx_led;
    logic [4:0]    fifo_count;
    logic          overflow;
    logic [7:0]    err_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    serial_echo_engine #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .ADD_VALUE    (1),
        .XOR_KEY      (8'h55),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_byte_received (rx_byte_received),
        .rx_data          (rx_data),
        .rx_err           (rx_err),
        .mode             (mode),
        .clr_status       (clr_status),
        .tx_data          (tx_data),
        .tx_data_ready    (tx_data_ready),
        .tx_data_copied   (tx_data_copied),
        .tx_busy          (tx_busy),
        .rx_led           (rx_led),
        .tx_led           (tx_led),
        .fifo_count       (fifo_count),
        .overflow         (overflow),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: copies a requested word at the first negedge it sees the request.
    logic       auto_tx = 1'b0;
    logic       prev_rdy = 1'b0;
    logic [7:0] got[$];
    int         rise[$];

    always @(negedge clk) begin
        if (tx_data_ready && !prev_rdy) rise.push_back(cyc);
        prev_rdy = tx_data_ready;
        if (auto_tx && tx_data_ready && !tx_data_copied) begin
            tx_data_copied = 1'b1;
            got.push_back(tx_data);
        end else begin
            tx_data_copied = 1'b0;
        end
    end

    // Reference transform from the mode table (ADD_VALUE=1, XOR_KEY=8'h55).
    function automatic logic [7:0] ref_xform(input logic [1:0] m, input logic [7:0] x);
        int r;
        r = 0;
        case (m)
            2'd0: r = x;
            2'd1: r = (x + 1) % 256;
            2'd2: r = x ^ 8'h55;
            default: for (int i = 0; i < 8; i++) if (x[i]) r = r | (1 << (7 - i));
        endcase
        return r[7:0];
    endfunction

    task automatic send(input logic [7:0] d, input logic e);
        @(negedge clk);
        rx_data = d;
        rx_err = e;
        rx_byte_received = 1'b1;
        @(negedge clk);
        rx_byte_received = 1'b0;
        rx_err = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got.size() >= n) break;
            @(negedge clk);
        end
        if (got.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        total++; if (tx_data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", tx_data_ready); end
        total++; if ({rx_led, tx_led} !== 2'b11) begin bad++; $display("FAIL reset_leds got=%b exp=11", {rx_led, tx_led}); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if ({overflow, err_count} !== 9'd0) begin bad++; $display("FAIL reset_status got=%b/%0d exp=0/0", overflow, err_count); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Capture 8'h41 in add mode, then probe LED on/off-guard boundaries with two more words.
    task automatic test_echo_add();
        int rx_lo;
        int tx_lo;
        bit ok;
        logic [7:0] e[3];
        e[0] = 8'h42; e[1] = 8'h11; e[2] = 8'h80;
        rx_lo = 0; tx_lo = 0;
        got.delete();
        auto_tx = 1'b1;
        mode = 2'd1;
        @(negedge clk);
        rx_data = 8'h41; rx_byte_received = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (!rx_led) rx_lo++;
            if (!tx_led) tx_lo++;
            if (i == 0) begin
                total++; if (fifo_count !== 5'd1) begin bad++; $display("FAIL cap_count got=%0d exp=1", fifo_count); end
                total++; if (rx_led !== 1'b0) begin bad++; $display("FAIL cap_rx_led got=%b exp=0", rx_led); end
                rx_byte_received = 1'b0;
            end
            if (i == 1) begin
                total++; if (tx_data !== 8'h42) begin bad++; $display("FAIL load_data got=%h exp=42", tx_data); end
                total++; if (tx_data_ready !== 1'b0) begin bad++; $display("FAIL early_ready got=%b exp=0", tx_data_ready); end
            end
            if (i == 2) begin
                total++; if (tx_data_ready !== 1'b1) begin bad++; $display("FAIL latency_ready got=%b exp=1", tx_data_ready); end
            end
            if (i == 20) begin rx_data = 8'h10; rx_byte_received = 1'b1; end
            if (i == 21) rx_byte_received = 1'b0;
            if (i == 32) begin
                total++; if (rx_led !== 1'b1) begin bad++; $display("FAIL rx_led_guard got=%b exp=1", rx_led); end
                rx_data = 8'h7F; rx_byte_received = 1'b1;
            end
            if (i == 33) rx_byte_received = 1'b0;
        end
        total++; if (rx_lo !== 28) begin bad++; $display("FAIL rx_led_low_cycles got=%0d exp=28", rx_lo); end
        total++; if (tx_lo !== 27) begin bad++; $display("FAIL tx_led_low_cycles got=%0d exp=27", tx_lo); end
        wait_got(3, 20, ok);
        total++; if (got.size() !== 3) begin bad++; $display("FAIL echo_add_n got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                total++; if (got[i] !== e[i]) begin bad++; $display("FAIL echo_add_%0d got=%h exp=%h", i, got[i], e[i]); end
            end
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_modes();
        logic [1:0] tm[4];
        logic [7:0] ti[4];
        logic [7:0] te[4];
        logic [7:0] x;
        logic [7:0] exp_v;
        bit ok;
        tm[0] = 2'd0; ti[0] = 8'h01; te[0] = 8'h01;
        tm[1] = 2'd2; ti[1] = 8'h01; te[1] = 8'h54;
        tm[2] = 2'd3; ti[2] = 8'h01; te[2] = 8'h80;
        tm[3] = 2'd1; ti[3] = 8'hFF; te[3] = 8'h00;
        for (int i = 0; i < 10; i++) begin
            got.delete();
            if (i < 4) begin
                mode = tm[i]; x = ti[i]; exp_v = te[i];
            end else begin
                mode = 2'($urandom_range(0, 3)); x = 8'($urandom); exp_v = ref_xform(mode, x);
            end
            send(x, 1'b0);
            wait_got(1, 30, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL mode_timeout idx=%0d got=none exp=%h", i, exp_v); end
            else if (got[0] !== exp_v) begin bad++; $display("FAIL mode%0d_x%h got=%h exp=%h", mode, x, got[0], exp_v); end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e[$];
        bit ok;
        got.delete(); rise.delete();
        mode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            e.push_back(8'($urandom));
            send(e[i], 1'b0);
        end
        wait_got(3, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
        if (ok && rise.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                total++; if (got[i] !== e[i]) begin bad++; $display("FAIL b2b_data_%0d got=%h exp=%h", i, got[i], e[i]); end
            end
            total++; if (rise[1] - rise[0] !== 5) begin bad++; $display("FAIL b2b_spacing1 got=%0d exp=5", rise[1] - rise[0]); end
            total++; if (rise[2] - rise[1] !== 5) begin bad++; $display("FAIL b2b_spacing2 got=%0d exp=5", rise[2] - rise[1]); end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        logic [7:0] e[$];
        logic [7:0] x;
        bit ok;
        got.delete();
        mode = 2'($urandom_range(0, 3));
        tx_busy = 1'b1;
        x = 8'($urandom);
        e.push_back(ref_xform(mode, x));
        send(x, 1'b0);
        wait_got(1, 20, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_first_word got=none exp=%h", e[0]); end
        for (int i = 0; i < DEPTH + 2; i++) begin
            x = 8'($urandom);
            if (q.size() < DEPTH) q.push_back(x);
            send(x, 1'b0);
        end
        @(negedge clk);
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        // Release the transmitter so the pop lands in the same cycle as the next capture.
        tx_busy = 1'b0;
        @(negedge clk);
        x = 8'($urandom);
        rx_data = x; rx_byte_received = 1'b1;
        @(negedge clk);
        rx_byte_received = 1'b0;
        q.push_back(x);
        total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL full_pop_count got=%0d exp=16", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pop_ovf got=%b exp=0", overflow); end
        foreach (q[i]) e.push_back(ref_xform(mode, q[i]));
        wait_got(e.size(), 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_drain got=%0d exp=%0d", got.size(), e.size()); end
        if (ok) begin
            for (int i = 0; i < e.size(); i++) begin
                total++; if (got[i] !== e[i]) begin bad++; $display("FAIL ovf_order_%0d got=%h exp=%h", i, got[i], e[i]); end
            end
        end
        repeat (8) @(negedge clk);
        total++; if (got.size() !== e.size()) begin bad++; $display("FAIL ovf_extra got=%0d exp=%0d", got.size(), e.size()); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL ovf_empty got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_errors();
        int n0;
        int model_err;
        got.delete();
        n0 = got.size();
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1);
        repeat (10) @(negedge clk);
        total++; if (got.size() !== n0) begin bad++; $display("FAIL err_no_tx got=%0d exp=%0d", got.size(), n0); end
        total++; if (err_count !== 8'd3) begin bad++; $display("FAIL err_count3 got=%0d exp=3", err_count); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL err_fifo got=%0d exp=0", fifo_count); end
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL err_clear got=%0d exp=0", err_count); end
        model_err = 0;
        for (int i = 0; i < 300; i++) begin
            send(8'($urandom), 1'b1);
            model_err = (model_err < 255) ? model_err + 1 : 255;
        end
        @(negedge clk);
        total++; if (err_count !== model_err[7:0]) begin bad++; $display("FAIL err_saturate got=%0d exp=%0d", err_count, model_err); end
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n0;
        repeat (40) @(negedge clk);
        auto_tx = 1'b0;
        send(8'h3C, 1'b0);
        send(8'hC3, 1'b0);
        @(negedge clk);
        total++; if (tx_data_ready !== 1'b1) begin bad++; $display("FAIL pre_rst_ready got=%b exp=1", tx_data_ready); end
        total++; if (fifo_count !== 5'd1) begin bad++; $display("FAIL pre_rst_count got=%0d exp=1", fifo_count); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (tx_data_ready !== 1'b0) begin bad++; $display("FAIL rst_async_ready got=%b exp=0", tx_data_ready); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL rst_async_count got=%0d exp=0", fifo_count); end
        total++; if ({rx_led, tx_led} !== 2'b11) begin bad++; $display("FAIL rst_async_leds got=%b exp=11", {rx_led, tx_led}); end
        @(negedge clk);
        rst = 1'b0;
        auto_tx = 1'b1;
        n0 = got.size();
        repeat (30) @(negedge clk);
        total++; if (got.size() !== n0) begin bad++; $display("FAIL post_rst_tx got=%0d exp=%0d", got.size(), n0); end
        total++; if (fifo_count !== 5'd0) begin bad++; $display("FAIL post_rst_count got=%0d exp=0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_echo_add();
        test_modes();
        test_back_to_back();
        test_overflow();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
